ram_stream_reader: RTL and testbench
====================================

# ram_stream_reader

Read-side controller for the team's simple dual-port RAM. It takes a burst request (start address and word count), drives the RAM read port, and absorbs the RAM's fixed one-cycle read latency. It streams the words out over a valid/ready interface through a two-entry output buffer, so downstream backpressure never drops or duplicates a word. It sits between the RAM's read interface, with `rclk` tied to `clk`, and any consumer such as a display, UART or checksum engine.

## Interface
- `SIZE`, default 8: word width; must match the RAM's `SIZE`.
- `DEPTH`, default 8: number of RAM entries; AW = $clog2(DEPTH).

- `clk`  in  1  single clock; the RAM read port runs on this clock.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  request strobe; sampled only in IDLE.
- `base`  in  AW  first read address; sampled with `start`.
- `count`  in  AW+1  number of words, 0..2^(AW+1)-1; sampled with `start`.
- `busy`  out  1  high while a burst is in progress.
- `done`  out  1  one-cycle pulse when a burst completes.
- `raddr`  out  AW  RAM read address.
- `read_data`  in  SIZE  RAM read data; equals mem[raddr] of the previous cycle.
- `out_data`  out  SIZE  stream data, valid at the head of the buffer.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready; transfer occurs when `out_valid` and `out_ready` are both high.

## Operation
- FSM states:
  - IDLE: `start`=1 with `count`≠0 → READ. Load the address pointer with `base` and the remaining-count with `count`.
  - IDLE: `start`=1 with `count`=0 → DONE.
  - READ: remaining reaches 0 after the last issue → DRAIN.
  - DRAIN: buffer empty, nothing in flight, and the last word transferred → DONE.
  - DONE: → IDLE unconditionally after one cycle.
- `start` outside IDLE is ignored.
- `raddr` equals the address pointer register.
- Issue condition, evaluated each cycle in READ: remaining≠0 and (buf_cnt + inflight − pop) < 2, where pop = `out_valid`&`out_ready`.
- On issue: the pointer increments, remaining decrements, and inflight is set for the next cycle.
- Address wrap: the pointer goes DEPTH−1 → 0, with an explicit compare for non-power-of-two DEPTH. `count` > DEPTH re-reads from the wrapped addresses.
- When inflight is set, `read_data` is written into the 2-entry buffer (write and pop may occur in the same cycle).
- The buffer never overflows. Occupancy plus in-flight reads is always ≤ 2.
- `out_data`/`out_valid` reflect the buffer head. `out_data` is held stable while `out_valid`=1 and `out_ready`=0.
- `busy` = state ∈ {READ, DRAIN}.
- `done` = state is DONE.
- Reset values:
  - state IDLE; `busy`=0, `done`=0, `out_valid`=0.
  - `raddr`=0, `out_data`=0.
  - buffer empty, inflight=0, remaining=0.
- Reset asserted mid-burst aborts immediately to the reset values. No `done` pulse is generated for the aborted burst.

## Timing
- Cycle 0: `start` sampled.
- Cycle 1: `busy`=1, `raddr`=`base`, first issue.
- Cycle 2: `read_data`=mem[`base`] is captured at the end of the cycle.
- Cycle 3: `out_valid`=1 with word 0. Start-to-first-valid latency is 3 cycles.
- With `out_ready` held high: one word per cycle, no bubbles. Words 0..N−1 appear on cycles 3..N+2.
- `done` pulses in the cycle after the last transfer, and `busy` is 0 in that same cycle.
- `start` is accepted again the cycle after `done`.
- `count`=0: `done`=1 on cycle 1, `busy` never rises, `out_valid` never rises.
- Backpressure: issue stalls within one cycle of `out_ready` dropping. At most 2 words are buffered. When `out_ready` returns, transfers resume on that same cycle.

## Test plan
- Reset: hold `rst`=0 with random inputs → `busy`=`done`=`out_valid`=0, `raddr`=0. Release reset with `start`=0 → all remain 0.
- Basic burst: DEPTH=8, mem[i]=0x10+i, `base`=2, `count`=4, `out_ready`=1 → `out_data` = 0x12, 0x13, 0x14, 0x15 on cycles 3–6, `done` on cycle 7, `busy` high on cycles 1–6.
- Wrap: `base`=6, `count`=4 → `raddr` sequence 6, 7, 0, 1; output 0x16, 0x17, 0x10, 0x11.
- Backpressure: `base`=0, `count`=6; `out_ready`=0 on cycles 4–6 → word 0x11 held stable throughout, `raddr` frozen, 6 words delivered in order with no duplicates, `done` one cycle after the 6th transfer.
- Edge starts:
  - `count`=0 → single `done` pulse on cycle 1, no valid.
  - `start` pulsed during READ → ignored; the burst length is unchanged.
- Reset mid-burst: assert `rst` on cycle 4 of a `count`=8 burst → outputs return to reset values asynchronously, no `done`. A new burst after release delivers correct data from its own `base`.

Source files
------------

// File: rtl/ram_stream_reader.sv
// Burst read controller for the simple dual-port RAM: issues reads, absorbs the
// one-cycle read latency and streams words out through a two-entry skid buffer.
module ram_stream_reader #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   base,
  input  logic [AW:0]     count,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   raddr,
  input  logic [SIZE-1:0] read_data,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  state_e          state_q;
  logic [AW-1:0]   ptr_q;
  logic [AW-1:0]   ptr_nxt;
  logic [AW:0]     rem_q;
  logic            infl_q;
  logic [1:0]      cnt_q;
  logic [1:0]      cnt_d;
  logic [SIZE-1:0] head_q;
  logic [SIZE-1:0] tail_q;
  logic            busy_q;
  logic            done_q;
  logic            pop;
  logic            issue;
  logic [2:0]      occ;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign raddr     = ptr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  assign pop     = out_valid & out_ready;
  // Words held plus the read still in flight must leave room after this cycle's pop.
  assign occ     = {1'b0, cnt_q} + {2'b00, infl_q};
  assign issue   = (state_q == READ) && (rem_q != '0) && (occ < (3'd2 + {2'b00, pop}));
  assign ptr_nxt = (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);

  always_comb begin
    cnt_d = cnt_q;
    case ({infl_q, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      infl_q  <= 1'b0;
      cnt_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      infl_q <= issue;
      cnt_q  <= cnt_d;

      // Buffer: head is the stream output, tail catches a word arriving under backpressure.
      if (pop) begin
        if (cnt_q == 2'd2) begin
          head_q <= tail_q;
          if (infl_q) tail_q <= read_data;
        end else if (infl_q) begin
          head_q <= read_data;
        end
      end else if (infl_q) begin
        if (cnt_q == 2'd0) head_q <= read_data;
        else               tail_q <= read_data;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              state_q <= READ;
              busy_q  <= 1'b1;
              ptr_q   <= base;
              rem_q   <= count;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            ptr_q <= ptr_nxt;
            rem_q <= rem_q - (AW+1)'(1);
            if (rem_q == (AW+1)'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if ((cnt_d == 2'd0) && !infl_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: RAM model with one-cycle read latency, scenario
// tasks and a queue-based expected-word model.
module tb_ram_stream_reader;
  localparam int SIZE  = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   base;
  logic [AW:0]     count;
  logic            busy;
  logic            done;
  logic [AW-1:0]   raddr;
  logic [SIZE-1:0] read_data;
  logic [SIZE-1:0] out_data;
  logic            out_valid;
  logic            out_ready;

  logic [SIZE-1:0] mem [DEPTH];

  int errors = 0;
  int checks = 0;

  logic [SIZE-1:0] got_q[$];
  int              xfer_q[$];
  logic [AW-1:0]   raddr_log[$];
  bit              busy_log[$];
  int              done_cyc;
  int              done_cnt;
  bit              busy_at_done;
  bit              any_valid;
  bit              unstable;

  ram_stream_reader #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
    .busy(busy), .done(done), .raddr(raddr), .read_data(read_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) read_data <= mem[raddr];

  function automatic logic [SIZE-1:0] ref_word(input int b, input int i);
    return mem[(b + i) % DEPTH];
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < DEPTH; i++) mem[i] = SIZE'(16 + i);
  endtask

  // mode 0: ready high; 1: ready low on cycles s_lo..s_hi; 2: random ready.
  // inj: cycle on which a stray start pulse is driven (-1 for none).
  task automatic run_burst(input int b, input int c, input int mode,
                           input int s_lo, input int s_hi, input int inj);
    logic            pv;
    logic            prd;
    logic [SIZE-1:0] pd;
    got_q.delete(); xfer_q.delete(); raddr_log.delete(); busy_log.delete();
    done_cyc = -1; done_cnt = 0; busy_at_done = 1'b0; any_valid = 1'b0; unstable = 1'b0;
    @(negedge clk);
    start = 1'b1; base = AW'(b); count = (AW+1)'(c); out_ready = 1'b1;
    pv = 1'b0; prd = 1'b1; pd = '0;
    for (int cyc = 1; cyc < 300; cyc++) begin
      @(negedge clk);
      start = (cyc == inj);
      if (cyc == inj) begin base = AW'(b + 3); count = (AW+1)'(2); end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(cyc >= s_lo && cyc <= s_hi);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      raddr_log.push_back(raddr);
      busy_log.push_back(busy);
      if (pv && !prd && (!out_valid || out_data !== pd)) unstable = 1'b1;
      if (out_valid) any_valid = 1'b1;
      if (out_valid && out_ready) begin got_q.push_back(out_data); xfer_q.push_back(cyc); end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; end
      end
      pv = out_valid; pd = out_data; prd = out_ready;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1)); base = AW'($urandom); count = (AW+1)'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({busy, done, out_valid} !== 3'b000 || raddr !== '0 || out_data !== '0) begin
        errors++;
        $display("FAIL reset_hold: busy=%b done=%b valid=%b raddr=%0d data=%h, need all 0",
                 busy, done, out_valid, raddr, out_data);
      end
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, out_valid} !== 3'b000 || raddr !== '0) begin
        errors++;
        $display("FAIL reset_release: busy=%b done=%b valid=%b raddr=%0d, need all 0",
                 busy, done, out_valid, raddr);
      end
    end
  endtask

  task automatic test_basic();
    int nb;
    fill_ramp();
    run_burst(2, 4, 0, 0, 0, -1);
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL basic_len: got %0d words, need 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== SIZE'(8'h12 + i) || xfer_q[i] != 3 + i) begin
        errors++;
        $display("FAIL basic_word%0d: %h at cycle %0d, need %h at cycle %0d",
                 i, got_q[i], xfer_q[i], SIZE'(8'h12 + i), 3 + i);
      end
    end
    nb = 0;
    foreach (busy_log[j]) if (busy_log[j]) nb++;
    checks++;
    if (done_cyc != 7 || done_cnt != 1 || busy_at_done !== 1'b0 || nb != 6 || !busy_log[0]) begin
      errors++;
      $display("FAIL basic_ctrl: done@%0d x%0d busy_at_done=%b busy_cycles=%0d, need done@7 x1 0 6",
               done_cyc, done_cnt, busy_at_done, nb);
    end
  endtask

  task automatic test_wrap();
    fill_ramp();
    run_burst(6, 4, 0, 0, 0, -1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (raddr_log.size() <= k || raddr_log[k] !== AW'((6 + k) % DEPTH)) begin
        errors++;
        $display("FAIL wrap_raddr%0d: %0d, need %0d", k,
                 (raddr_log.size() > k) ? int'(raddr_log[k]) : -1, (6 + k) % DEPTH);
      end
    end
    checks++;
    if (got_q.size() != 4 || got_q[0] !== 8'h16 || got_q[1] !== 8'h17 ||
        got_q[2] !== 8'h10 || got_q[3] !== 8'h11) begin
      errors++;
      $display("FAIL wrap_data: %0d words %p, need 16 17 10 11", got_q.size(), got_q);
    end
  endtask

  task automatic test_backpressure();
    fill_ramp();
    run_burst(0, 6, 1, 4, 6, -1);
    checks++;
    if (got_q.size() != 6) begin
      errors++; $display("FAIL bp_len: got %0d words, need 6", got_q.size());
    end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== ref_word(0, i)) begin
        errors++; $display("FAIL bp_word%0d: %h, need %h", i, got_q[i], ref_word(0, i));
      end
    end
    checks++;
    if (unstable || xfer_q.size() < 2 || xfer_q[1] != 7) begin
      errors++;
      $display("FAIL bp_hold: unstable=%b word1_cycle=%0d, need 0 and 7", unstable,
               (xfer_q.size() > 1) ? xfer_q[1] : -1);
    end
    checks++;
    if (raddr_log.size() < 6 || raddr_log[4] !== raddr_log[3] || raddr_log[5] !== raddr_log[3]) begin
      errors++; $display("FAIL bp_raddr_frozen: raddr moved while stalled");
    end
    checks++;
    if (xfer_q.size() == 0 || done_cyc != xfer_q[xfer_q.size()-1] + 1 || done_cnt != 1) begin
      errors++;
      $display("FAIL bp_done: done@%0d x%0d, need one cycle after last transfer", done_cyc, done_cnt);
    end
  endtask

  task automatic test_count_zero();
    int nb;
    run_burst(3, 0, 0, 0, 0, -1);
    nb = 0;
    foreach (busy_log[j]) if (busy_log[j]) nb++;
    checks++;
    if (done_cyc != 1 || done_cnt != 1 || any_valid || nb != 0) begin
      errors++;
      $display("FAIL count_zero: done@%0d x%0d valid=%b busy_cycles=%0d, need done@1 x1 0 0",
               done_cyc, done_cnt, any_valid, nb);
    end
  endtask

  task automatic test_start_in_read();
    fill_ramp();
    run_burst(2, 4, 0, 0, 0, 2);
    checks++;
    if (got_q.size() != 4 || done_cyc != 7 || done_cnt != 1) begin
      errors++;
      $display("FAIL start_in_read: %0d words done@%0d x%0d, need 4 words done@7 x1",
               got_q.size(), done_cyc, done_cnt);
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== ref_word(2, i)) begin
        errors++; $display("FAIL start_in_read_word%0d: %h, need %h", i, got_q[i], ref_word(2, i));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit saw_done;
    fill_ramp();
    saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1; base = AW'(1); count = (AW+1)'(8); out_ready = 1'b1;
    for (int cyc = 1; cyc < 4; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, out_valid} !== 3'b000 || raddr !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b valid=%b raddr=%0d data=%h, need all 0",
               busy, done, out_valid, raddr, out_data);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++; $display("FAIL mid_reset_nodone: done or busy seen after abort, need none");
    end
    run_burst(5, 3, 0, 0, 0, -1);
    checks++;
    if (got_q.size() != 3 || got_q[0] !== ref_word(5, 0) || got_q[1] !== ref_word(5, 1) ||
        got_q[2] !== ref_word(5, 2) || done_cnt != 1) begin
      errors++;
      $display("FAIL mid_reset_next: %0d words %p done x%0d, need %h %h %h x1", got_q.size(),
               got_q, done_cnt, ref_word(5, 0), ref_word(5, 1), ref_word(5, 2));
    end
  endtask

  task automatic test_random();
    int b;
    int c;
    int bad;
    for (int i = 0; i < DEPTH; i++) mem[i] = SIZE'($urandom);
    for (int t = 0; t < 8; t++) begin
      b = $urandom_range(0, DEPTH - 1);
      c = $urandom_range(1, 15);
      run_burst(b, c, 2, 0, 0, -1);
      bad = 0;
      for (int i = 0; i < got_q.size() && i < c; i++) if (got_q[i] !== ref_word(b, i)) bad++;
      checks++;
      if (got_q.size() != c || bad != 0) begin
        errors++;
        $display("FAIL rand%0d_data: base=%0d count=%0d got %0d words, %0d wrong", t, b, c,
                 got_q.size(), bad);
      end
      checks++;
      if (unstable || done_cnt != 1 || xfer_q.size() == 0 ||
          done_cyc != xfer_q[xfer_q.size()-1] + 1 || busy_at_done !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_ctrl: unstable=%b done@%0d x%0d busy_at_done=%b", t, unstable,
                 done_cyc, done_cnt, busy_at_done);
      end
    end
  endtask

  initial begin
    start = 1'b0; base = '0; count = '0; out_ready = 1'b1;
    fill_ramp();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_count_zero();
    test_start_in_read();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
